hc_mmio_responder: RTL and testbench
====================================

HC_MMIO_RESPONDER -- requirements
Module: hc_mmio_responder

Interface
REQ-001 SHALL have parameter HC_BUFFER_SIZE, default 2, number of buffer descriptor slots.
REQ-002 SHALL have parameter AFU_ID_L, default 64'h0, low 64 bits of AFU UUID.
REQ-003 SHALL have parameter AFU_ID_H, default 64'h0, high 64 bits of AFU UUID.
REQ-004 SHALL have port: clk  input  1  single clock for all logic.
REQ-005 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: cp2af_mmio_c0rx  input  t_if_ccip_c0_Rx  MMIO requests (hdr, data, mmioRdValid, mmioWrValid).
REQ-007 SHALL have port: af2cp_mmio_c2tx  output  t_if_ccip_c2_Tx  MMIO read response (hdr.tid, data, mmioRdValid).
REQ-008 SHALL have port: hc_status  input  32  status word, read-only from host.
REQ-009 SHALL have port: hc_dsm_base  output  64  DSM base address.
REQ-010 SHALL have port: hc_control  output  32  last control word written.
REQ-011 SHALL have port: hc_buffer  output  HC_BUFFER_SIZE x t_hc_buffer  buffer address/size descriptors.
REQ-012 SHALL have port: hc_start  output  1  one-cycle pulse on control write of 32'h3.
REQ-013 SHALL have port: hc_stop  output  1  one-cycle pulse on control write of 32'h7.

Function
REQ-014 SHALL decode hdr.address as DWORD units; requests with address >= 'h400 SHALL be ignored (no write, no response).
REQ-015 SHALL map byte offsets: 0x000 DFH, 0x008 AFU_ID_L, 0x010 AFU_ID_H, 0x018/0x020 reserved (read 0), 0x100 status, 0x110 DSM base, 0x118 control, 0x120+0x10*i buffer i address, 0x128+0x10*i buffer i size.
REQ-016 SHALL return DFH = 64'h1000_0100_0000_0000 (AFU type, EOL set, next offset 0).
REQ-017 SHALL update a writable register on mmioWrValid with the full 64-bit data for DSM base and buffer address, low 32 bits for control and size; other offsets ignore writes.
REQ-018 SHALL make a written value visible on the output the cycle after mmioWrValid.
REQ-019 SHALL, on mmioRdValid, register the request tid and selected data and assert af2cp_mmio_c2tx.mmioRdValid exactly 1 cycle later for exactly 1 cycle.
REQ-020 SHALL return hc_status zero-extended to 64 bits at 0x100; writable registers read back their current value zero-extended; unmapped offsets below 'h400 read 64'h0.
REQ-021 SHALL accept one request per cycle with no stall; back-to-back reads SHALL produce back-to-back responses with matching tids in order.
REQ-022 SHALL return the updated value for a read arriving the cycle after a write to the same offset.
REQ-023 SHALL, if mmioRdValid and mmioWrValid are both asserted (protocol violation), perform the write and answer the read with the pre-write value.
REQ-024 SHALL pulse hc_start (hc_stop) the cycle after a control write of 32'h3 (32'h7); other control values SHALL produce no pulse; repeated writes SHALL pulse each time.
REQ-025 SHALL ignore buffer-range offsets at or beyond index HC_BUFFER_SIZE.
REQ-026 SHALL drive af2cp_mmio_c2tx.hdr fields other than tid to 0.

Reset
REQ-027 SHALL, while reset_n is low, drive hc_dsm_base, hc_control (HC_CONTROL_ASSERT_RST = 0), all hc_buffer fields, hc_start, hc_stop and c2tx mmioRdValid to 0.
REQ-028 SHALL discard a read pending when reset asserts; no response SHALL issue after reset release for a pre-reset request.

Verification
REQ-029 Read 0x000 with tid 5 -> next cycle mmioRdValid=1, tid=5, data=64'h1000_0100_0000_0000.
REQ-030 Write 0x120=64'hDEAD_BEEF_0000_1000, 0x128=0x40, read both -> hc_buffer[0]={64'hDEAD_BEEF_0000_1000,32'h40}, reads return same values.
REQ-031 Write control 32'h3 then 32'h7 then 32'h1 -> hc_start one pulse, hc_stop one pulse, no pulse on 32'h1, hc_control=32'h1.
REQ-032 Four back-to-back reads tids 1..4 to 0x008,0x010,0x100,0x300 -> four consecutive responses tids 1..4 with AFU_ID_L, AFU_ID_H, hc_status, 0.
REQ-033 Write 0x110 at address DWORD 'h400+'h44 -> hc_dsm_base unchanged; read there -> no response.
REQ-034 Issue read, assert reset_n low same cycle -> no response; all outputs 0 until first post-reset write.

Source files
------------

// File: rtl/hc_mmio_responder.sv
// Host-control MMIO responder: decodes CCI-P MMIO reads/writes into a small
// register file (DFH, AFU ID, status, DSM base, control, buffer descriptors)
// and returns single-cycle-latency read responses.

package hc_mmio_pkg;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [63:0]         data;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [6:0] rsvd;
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] size;
    } t_hc_buffer;

    localparam logic [31:0] HC_CONTROL_ASSERT_RST = 32'h0;

endpackage

module hc_mmio_responder
    import hc_mmio_pkg::*;
#(
    parameter int          HC_BUFFER_SIZE = 2,
    parameter logic [63:0] AFU_ID_L       = 64'h0,
    parameter logic [63:0] AFU_ID_H       = 64'h0
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  t_if_ccip_c0_Rx                      cp2af_mmio_c0rx,
    output t_if_ccip_c2_Tx                      af2cp_mmio_c2tx,
    input  logic [31:0]                         hc_status,
    output logic [63:0]                         hc_dsm_base,
    output logic [31:0]                         hc_control,
    output t_hc_buffer [HC_BUFFER_SIZE-1:0]     hc_buffer,
    output logic                                hc_start,
    output logic                                hc_stop
);

    // AFU type, end-of-list set, next-DFH offset 0
    localparam logic [63:0] DFH = 64'h1000_0100_0000_0000;

    logic [11:0] byteOff;
    logic        inRange;
    logic        wrEn;
    logic        rdEn;
    logic [63:0] rdData;

    logic [63:0]                        dsm_q, dsm_d;
    logic [31:0]                        ctrl_q, ctrl_d;
    t_hc_buffer [HC_BUFFER_SIZE-1:0]    buf_q, buf_d;
    logic                               start_q, start_d;
    logic                               stop_q, stop_d;
    logic                               rspValid_q, rspValid_d;
    logic [8:0]                         rspTid_q, rspTid_d;
    logic [63:0]                        rspData_q, rspData_d;

    logic unusedHdrBits;

    // The address is in DWORDs; anything at or above DWORD 'h400 is outside
    // this AFU's window and must be completely ignored.
    assign byteOff = {cp2af_mmio_c0rx.hdr.address[9:0], 2'b00};
    assign inRange = (cp2af_mmio_c0rx.hdr.address[15:10] == 6'd0);
    assign wrEn    = cp2af_mmio_c0rx.mmioWrValid & inRange;
    assign rdEn    = cp2af_mmio_c0rx.mmioRdValid & inRange;

    assign unusedHdrBits = ^{cp2af_mmio_c0rx.hdr.length, cp2af_mmio_c0rx.hdr.rsvd};

    // Register decode: selects read data from current (pre-write) state and
    // computes next state for writable registers and the start/stop pulses.
    always_comb begin
        rdData  = '0;
        dsm_d   = dsm_q;
        ctrl_d  = ctrl_q;
        buf_d   = buf_q;
        start_d = 1'b0;
        stop_d  = 1'b0;

        case (byteOff)
            12'h000: rdData = DFH;
            12'h008: rdData = AFU_ID_L;
            12'h010: rdData = AFU_ID_H;
            12'h100: rdData = {32'h0, hc_status};
            12'h110: begin
                rdData = dsm_q;
                if (wrEn) begin
                    dsm_d = cp2af_mmio_c0rx.data;
                end
            end
            12'h118: begin
                rdData = {32'h0, ctrl_q};
                if (wrEn) begin
                    ctrl_d  = cp2af_mmio_c0rx.data[31:0];
                    start_d = (cp2af_mmio_c0rx.data[31:0] == 32'h3);
                    stop_d  = (cp2af_mmio_c0rx.data[31:0] == 32'h7);
                end
            end
            default: begin
                for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
                    if (byteOff == 12'h120 + 12'(16 * i)) begin
                        rdData = buf_q[i].addr;
                        if (wrEn) begin
                            buf_d[i].addr = cp2af_mmio_c0rx.data;
                        end
                    end else if (byteOff == 12'h128 + 12'(16 * i)) begin
                        rdData = {32'h0, buf_q[i].size};
                        if (wrEn) begin
                            buf_d[i].size = cp2af_mmio_c0rx.data[31:0];
                        end
                    end
                end
            end
        endcase

        rspValid_d = rdEn;
        rspTid_d   = rdEn ? cp2af_mmio_c0rx.hdr.tid : 9'h0;
        rspData_d  = rdEn ? rdData : 64'h0;
    end

    // State and response registers; reset also drops any in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dsm_q      <= '0;
            ctrl_q     <= HC_CONTROL_ASSERT_RST;
            buf_q      <= '0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            rspValid_q <= 1'b0;
            rspTid_q   <= '0;
            rspData_q  <= '0;
        end else begin
            dsm_q      <= dsm_d;
            ctrl_q     <= ctrl_d;
            buf_q      <= buf_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            rspValid_q <= rspValid_d;
            rspTid_q   <= rspTid_d;
            rspData_q  <= rspData_d;
        end
    end

    assign hc_dsm_base = dsm_q;
    assign hc_control  = ctrl_q;
    assign hc_buffer   = buf_q;
    assign hc_start    = start_q;
    assign hc_stop     = stop_q;

    assign af2cp_mmio_c2tx.hdr.rsvd    = '0;
    assign af2cp_mmio_c2tx.hdr.tid     = rspTid_q;
    assign af2cp_mmio_c2tx.mmioRdValid = rspValid_q;
    assign af2cp_mmio_c2tx.data        = rspData_q;

endmodule

// File: tb/tb_hc_mmio_responder.sv
// Directed bench for hc_mmio_responder: a vector table of single requests
// followed by hand-written multi-cycle sequences.

module tb_hc_mmio_responder;
    import hc_mmio_pkg::*;

    localparam logic [63:0] AFU_L  = 64'h1122_3344_5566_7788;
    localparam logic [63:0] AFU_H  = 64'h99AA_BBCC_DDEE_FF00;
    localparam logic [63:0] DFH    = 64'h1000_0100_0000_0000;
    localparam logic [31:0] STATUS = 32'hCAFE_0001;

    localparam logic [63:0] VD = 64'hDEAD_BEEF_0000_1000;
    localparam logic [31:0] VS = 32'h40;
    localparam logic [63:0] VM = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] VA = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] VN = 64'hFEDC_BA98_7654_3210;

    logic            clk = 1'b0;
    logic            resetN;
    t_if_ccip_c0_Rx  c0rx;
    t_if_ccip_c2_Tx  c2tx;
    logic [31:0]     hcStatus;
    logic [63:0]     hcDsmBase;
    logic [31:0]     hcControl;
    t_hc_buffer [1:0] hcBuffer;
    logic            hcStart;
    logic            hcStop;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [63:0] data;
        logic [8:0]  tid;
        logic        expRsp;
        logic [63:0] expData;
        logic        expStart;
        logic        expStop;
        logic [31:0] expCtrl;
        logic [63:0] expDsm;
        logic [63:0] expB0a;
        logic [31:0] expB0s;
        logic [63:0] expB1a;
    } vec_t;

    vec_t vecs[$];

    hc_mmio_responder #(
        .HC_BUFFER_SIZE (2),
        .AFU_ID_L       (AFU_L),
        .AFU_ID_H       (AFU_H)
    ) dut (
        .clk             (clk),
        .reset_n         (resetN),
        .cp2af_mmio_c0rx (c0rx),
        .af2cp_mmio_c2tx (c2tx),
        .hc_status       (hcStatus),
        .hc_dsm_base     (hcDsmBase),
        .hc_control      (hcControl),
        .hc_buffer       (hcBuffer),
        .hc_start        (hcStart),
        .hc_stop         (hcStop)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic wr, input logic rd, input logic [15:0] addr,
                                   input logic [63:0] data, input logic [8:0] tid,
                                   input logic expRsp, input logic [63:0] expData,
                                   input logic expStart, input logic expStop,
                                   input logic [31:0] expCtrl, input logic [63:0] expDsm,
                                   input logic [63:0] expB0a, input logic [31:0] expB0s,
                                   input logic [63:0] expB1a);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.data = data; v.tid = tid;
        v.expRsp = expRsp; v.expData = expData; v.expStart = expStart; v.expStop = expStop;
        v.expCtrl = expCtrl; v.expDsm = expDsm; v.expB0a = expB0a; v.expB0s = expB0s;
        v.expB1a = expB1a;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] addr,
                                 input logic [63:0] data, input logic [8:0] tid);
        c0rx.mmioWrValid = wr;
        c0rx.mmioRdValid = rd;
        c0rx.hdr.address = addr;
        c0rx.hdr.length  = 2'b01;
        c0rx.hdr.rsvd    = 1'b0;
        c0rx.hdr.tid     = tid;
        c0rx.data        = data;
    endtask

    task automatic checkResponse(input string name, input logic expValid,
                                 input logic [8:0] expTid, input logic [63:0] expData);
        checkOutput({name, " rdValid"}, 64'(c2tx.mmioRdValid), 64'(expValid));
        if (expValid) begin
            checkOutput({name, " tid"}, 64'(c2tx.hdr.tid), 64'(expTid));
            checkOutput({name, " data"}, c2tx.data, expData);
            checkOutput({name, " hdrRsvd"}, 64'(c2tx.hdr.rsvd), 64'h0);
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " rdValid"}, 64'(c2tx.mmioRdValid), 64'h0);
        checkOutput({name, " dsm"}, hcDsmBase, 64'h0);
        checkOutput({name, " ctrl"}, 64'(hcControl), 64'h0);
        checkOutput({name, " b0addr"}, hcBuffer[0].addr, 64'h0);
        checkOutput({name, " b0size"}, 64'(hcBuffer[0].size), 64'h0);
        checkOutput({name, " b1addr"}, hcBuffer[1].addr, 64'h0);
        checkOutput({name, " b1size"}, 64'(hcBuffer[1].size), 64'h0);
        checkOutput({name, " start"}, 64'(hcStart), 64'h0);
        checkOutput({name, " stop"}, 64'(hcStop), 64'h0);
    endtask

    initial begin
        resetN   = 1'b0;
        hcStatus = STATUS;
        applyStimulus(1'b0, 1'b0, 16'h0, 64'h0, 9'h0);

        // Single-request vectors; state columns hold the expected register
        // contents after the request has been applied.
        vecs.push_back(mkVec(0,1,16'h0000,64'h0,9'd5,   1,DFH, 0,0,32'h0,64'h0,64'h0,32'h0,64'h0));
        vecs.push_back(mkVec(1,0,16'h0048,VD,9'd0,      0,64'h0,0,0,32'h0,64'h0,VD,32'h0,64'h0));
        vecs.push_back(mkVec(1,0,16'h004A,64'hFFFF_FFFF_0000_0040,9'd0, 0,64'h0,0,0,32'h0,64'h0,VD,VS,64'h0));
        vecs.push_back(mkVec(0,1,16'h0048,64'h0,9'd7,   1,VD, 0,0,32'h0,64'h0,VD,VS,64'h0));
        vecs.push_back(mkVec(0,1,16'h004A,64'h0,9'd8,   1,64'h40,0,0,32'h0,64'h0,VD,VS,64'h0));
        vecs.push_back(mkVec(0,1,16'h0002,64'h0,9'd1,   1,AFU_L,0,0,32'h0,64'h0,VD,VS,64'h0));
        vecs.push_back(mkVec(0,1,16'h0004,64'h0,9'h1FF, 1,AFU_H,0,0,32'h0,64'h0,VD,VS,64'h0));
        vecs.push_back(mkVec(0,1,16'h0006,64'h0,9'd2,   1,64'h0,0,0,32'h0,64'h0,VD,VS,64'h0));
        vecs.push_back(mkVec(0,1,16'h0008,64'h0,9'd3,   1,64'h0,0,0,32'h0,64'h0,VD,VS,64'h0));
        vecs.push_back(mkVec(1,0,16'h0000,64'hFFFF_FFFF_FFFF_FFFF,9'd0, 0,64'h0,0,0,32'h0,64'h0,VD,VS,64'h0));
        vecs.push_back(mkVec(0,1,16'h0000,64'h0,9'd4,   1,DFH, 0,0,32'h0,64'h0,VD,VS,64'h0));
        vecs.push_back(mkVec(1,0,16'h0044,VM,9'd0,      0,64'h0,0,0,32'h0,VM,VD,VS,64'h0));
        vecs.push_back(mkVec(0,1,16'h0044,64'h0,9'd6,   1,VM,  0,0,32'h0,VM,VD,VS,64'h0));
        vecs.push_back(mkVec(1,0,16'h0050,64'h7777,9'd0,0,64'h0,0,0,32'h0,VM,VD,VS,64'h0));
        vecs.push_back(mkVec(0,1,16'h0050,64'h0,9'd10,  1,64'h0,0,0,32'h0,VM,VD,VS,64'h0));
        vecs.push_back(mkVec(0,1,16'h0052,64'h0,9'd11,  1,64'h0,0,0,32'h0,VM,VD,VS,64'h0));
        vecs.push_back(mkVec(1,0,16'h004C,VA,9'd0,      0,64'h0,0,0,32'h0,VM,VD,VS,VA));
        vecs.push_back(mkVec(0,1,16'h004E,64'h0,9'd12,  1,64'h0,0,0,32'h0,VM,VD,VS,VA));
        vecs.push_back(mkVec(0,1,16'h004C,64'h0,9'd13,  1,VA,  0,0,32'h0,VM,VD,VS,VA));
        vecs.push_back(mkVec(1,0,16'h0444,64'h5555,9'd0,0,64'h0,0,0,32'h0,VM,VD,VS,VA));
        vecs.push_back(mkVec(0,1,16'h0444,64'h0,9'd14,  0,64'h0,0,0,32'h0,VM,VD,VS,VA));
        vecs.push_back(mkVec(0,1,16'h0040,64'h0,9'd15,  1,{32'h0,STATUS},0,0,32'h0,VM,VD,VS,VA));
        vecs.push_back(mkVec(1,0,16'h0046,64'h3,9'd0,   0,64'h0,1,0,32'h3,VM,VD,VS,VA));
        vecs.push_back(mkVec(1,0,16'h0046,64'hFFFF_FFFF_0000_0007,9'd0, 0,64'h0,0,1,32'h7,VM,VD,VS,VA));
        vecs.push_back(mkVec(1,0,16'h0046,64'h1,9'd0,   0,64'h0,0,0,32'h1,VM,VD,VS,VA));
        vecs.push_back(mkVec(0,1,16'h0046,64'h0,9'd16,  1,64'h1,0,0,32'h1,VM,VD,VS,VA));

        #1;
        checkAllZero("reset");
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        // Table: one request, check one cycle later, then check the
        // following idle cycle shows no lingering response or pulse.
        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].tid);
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 16'h0, 64'h0, 9'h0);
            checkResponse($sformatf("v%0d", i), vecs[i].expRsp, vecs[i].tid, vecs[i].expData);
            checkOutput($sformatf("v%0d start", i), 64'(hcStart), 64'(vecs[i].expStart));
            checkOutput($sformatf("v%0d stop", i), 64'(hcStop), 64'(vecs[i].expStop));
            checkOutput($sformatf("v%0d ctrl", i), 64'(hcControl), 64'(vecs[i].expCtrl));
            checkOutput($sformatf("v%0d dsm", i), hcDsmBase, vecs[i].expDsm);
            checkOutput($sformatf("v%0d b0addr", i), hcBuffer[0].addr, vecs[i].expB0a);
            checkOutput($sformatf("v%0d b0size", i), 64'(hcBuffer[0].size), 64'(vecs[i].expB0s));
            checkOutput($sformatf("v%0d b1addr", i), hcBuffer[1].addr, vecs[i].expB1a);
            @(negedge clk);
            checkOutput($sformatf("v%0d idle rdValid", i), 64'(c2tx.mmioRdValid), 64'h0);
            checkOutput($sformatf("v%0d idle start", i), 64'(hcStart), 64'h0);
            checkOutput($sformatf("v%0d idle stop", i), 64'(hcStop), 64'h0);
        end

        // Four back-to-back reads must come back on consecutive cycles in order.
        begin
            logic [15:0] bAddr [4];
            logic [63:0] bExp [4];
            bAddr[0] = 16'h0002; bExp[0] = AFU_L;
            bAddr[1] = 16'h0004; bExp[1] = AFU_H;
            bAddr[2] = 16'h0040; bExp[2] = {32'h0, STATUS};
            bAddr[3] = 16'h00C0; bExp[3] = 64'h0;
            for (int k = 0; k <= 4; k++) begin
                @(negedge clk);
                if (k > 0) checkResponse($sformatf("b2b%0d", k - 1), 1'b1, 9'(k), bExp[k - 1]);
                if (k < 4) applyStimulus(1'b0, 1'b1, bAddr[k], 64'h0, 9'(k + 1));
                else       applyStimulus(1'b0, 1'b0, 16'h0, 64'h0, 9'h0);
            end
            @(negedge clk);
            checkResponse("b2b end", 1'b0, 9'h0, 64'h0);
        end

        // Read and write together answer with the old value; a read right
        // after the write sees the new one.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 16'h0044, VN, 9'd20);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 16'h0044, 64'h0, 9'd21);
        checkResponse("rdwr", 1'b1, 9'd20, VM);
        checkOutput("rdwr dsm", hcDsmBase, VN);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0, 64'h0, 9'h0);
        checkResponse("rdAfterWr", 1'b1, 9'd21, VN);

        // Back-to-back start writes pulse each time.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 16'h0046, 64'h3, 9'h0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 16'h0046, 64'h3, 9'h0);
        checkOutput("start rep1", 64'(hcStart), 64'h1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0, 64'h0, 9'h0);
        checkOutput("start rep2", 64'(hcStart), 64'h1);
        checkOutput("start rep2 stop", 64'(hcStop), 64'h0);
        @(negedge clk);
        checkOutput("start rep end", 64'(hcStart), 64'h0);

        // A read issued as reset asserts must never be answered.
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 16'h0000, 64'h0, 9'd30);
        resetN = 1'b0;
        #1;
        checkAllZero("inReset");
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0, 64'h0, 9'h0);
        resetN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkAllZero($sformatf("postReset%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
